magnitude_squared_cal: RTL and testbench
========================================

Name: magnitude_squared_cal

Overview:
Computes the squared magnitude I^2 + Q^2 of one signed complex sample. It sits directly upstream of square_root_cal in the absolute-value chain, and its output drives square_root_cal's inputData. It uses a serial shift-add multiplier, one partial product per clock, so the DSP-free datapath stays small. A valid/ready handshake paces samples in, and a one-cycle valid pulse marks each result.

Parameters:
INPUT_DATA_WIDTH, 36, width of each signed I/Q input sample (two's complement).
OUTPUT_DATA_WIDTH, 72, unsigned result width; must equal 2*INPUT_DATA_WIDTH (holds 2*(2^(W-1))^2 = 2^(2W-1)).

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
inputValid  input  1  the inputI/inputQ pair is valid this cycle.
inputI  input  INPUT_DATA_WIDTH  signed in-phase sample.
inputQ  input  INPUT_DATA_WIDTH  signed quadrature sample.
inputReady  output  1  the block accepts a sample this cycle (high only in IDLE).
outputValid  output  1  one-cycle pulse: outputData holds a new result.
outputData  output  OUTPUT_DATA_WIDTH  unsigned I^2+Q^2, feeds square_root_cal.inputData.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, outputValid=0, outputData=0.
  - Accumulator, bit counter and operand registers are cleared.
  - inputReady=1 once reset is released.
- State machine: IDLE -> SQUARE_I -> SQUARE_Q -> DONE -> IDLE.
- IDLE:
  - inputReady=1 (combinational decode of state).
  - On a rising edge with inputValid=1, the sample is accepted:
    - magI=|inputI| and magQ=|inputQ| are latched as unsigned INPUT_DATA_WIDTH values (-2^(W-1) maps to 2^(W-1), no saturation).
    - The accumulator and bit counter are cleared; state -> SQUARE_I.
  - inputValid=0 in IDLE: no state change.
- SQUARE_I, for counter k = 0..W-1, one bit per edge:
  - If magI[k]=1, acc += zero_extend(magI) << k.
  - k increments; at k=W-1 the counter resets to 0 and state -> SQUARE_Q.
- SQUARE_Q: identical procedure using magQ, adding into the same accumulator; after k=W-1, state -> DONE.
- DONE, one edge:
  - outputData <= acc; outputValid <= 1; state -> IDLE.
  - outputValid is cleared on the following edge unless a new DONE occurs (it cannot occur back-to-back).
- Arithmetic:
  - All accumulation is unsigned, OUTPUT_DATA_WIDTH bits wide.
  - No overflow is possible by construction; the maximum is 2^(2W-1).
- Latency and throughput:
  - outputValid goes high 2W+1 rising edges after the accepting edge (W=36: 73 edges).
  - inputReady returns high in the same cycle outputValid is high.
  - Throughput: one sample per 2W+2 cycles.
- Holding: outputData holds its value until the next DONE. Downstream samples it on outputValid.
- inputValid while busy: inputI/inputQ are ignored and no sample is queued. Upstream must hold inputValid until it sees inputReady=1 at the edge.
- inputValid held high continuously: a new sample is accepted on the edge where the state is IDLE, i.e. the edge right after the outputValid cycle.
- Reset mid-operation: the computation is aborted immediately. No outputValid is produced for it, and outputData returns to 0.
- Zero operands: the result is 0 with normal latency and outputValid still pulses.

Decomposition:
- Shared package or header: state encodings IDLE=0, SQUARE_I=1, SQUARE_Q=2, DONE=3, plus the default widths 36/72, also used by square_root_cal and its benches.
- One natural sub-module: serial_squarer, containing the counter, shift-add accumulate and done flag, reused for I then Q.
  - The top-level FSM sequences it and handles the abs conversion and the handshake.
  - A single inline implementation is also acceptable.

Test Plan:
- Reset then I=3, Q=4 with inputValid for one cycle -> inputReady drops next cycle; outputValid pulses exactly 73 edges after acceptance with outputData=25.
- I=-120, Q=-90 -> outputData=22500; chaining into square_root_cal yields 150.
- I=Q=-2^35 (most negative) -> outputData=2^71 (bit 71 set, all others 0), no overflow.
- inputValid held high with sequence (1,1), (0,0), (-7,24) -> results 2, 0, 625 on consecutive outputValid pulses, each accepted the edge after the previous pulse. inputI/Q changes during busy cycles are ignored.
- Assert reset=0 asynchronously midway through SQUARE_Q (between edges) -> outputValid=0, outputData=0 and inputReady=1 immediately after release, with no stale result pulse. A following I=5, Q=12 sample gives 169.
- I=0, Q=0 -> outputValid pulses with outputData=0; the previous result is overwritten.

Source files
------------

// File: rtl/magnitude_squared_cal_pkg.sv
// Shared definitions for the magnitude-squared / square-root chain:
// default sample widths and the squarer sequencing states.
package magnitude_squared_cal_pkg;

   localparam int unsigned MSC_INPUT_DATA_WIDTH  = 36;
   localparam int unsigned MSC_OUTPUT_DATA_WIDTH = 2 * MSC_INPUT_DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SQUARE_I = 2'd1,
      ST_SQUARE_Q = 2'd2,
      ST_DONE     = 2'd3
   } msc_state_e;

   // Counter width needed to walk every bit of an IN_W-bit operand.
   function automatic int unsigned msc_cnt_width(input int unsigned in_w);
      return (in_w > 1) ? $clog2(in_w) : 1;
   endfunction

endpackage

// File: rtl/magnitude_squared_cal_serial_squarer.sv
// Serial shift-add squarer: one partial product of operand*operand per
// step, accumulated into a shared OUT_W-bit register so it can be reused
// for I^2 then Q^2 without clearing in between.
module magnitude_squared_cal_serial_squarer
   import magnitude_squared_cal_pkg::*;
#(
   parameter int unsigned IN_W  = MSC_INPUT_DATA_WIDTH,
   parameter int unsigned OUT_W = MSC_OUTPUT_DATA_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             step_i,
   input  logic [IN_W-1:0]  operand_i,
   output logic [OUT_W-1:0] acc_o,
   output logic             last_o
);

   localparam int unsigned CNT_W = msc_cnt_width(IN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] operand_ext;

   assign operand_ext = {{(OUT_W - IN_W){1'b0}}, operand_i};
   assign last_o      = (cnt_q == CNT_LAST);
   assign acc_o       = acc_q;

   // Next-state: clear wins; a step adds operand<<k when operand bit k is set
   // and the bit counter wraps to 0 after the last bit.
   always_comb begin
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (clear_i) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (step_i) begin
         if (operand_i[cnt_q]) begin
            acc_d = acc_q + (operand_ext << cnt_q);
         end
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Counter and accumulator registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/magnitude_squared_cal.sv
// Squared magnitude I^2 + Q^2 of one signed complex sample, computed with a
// serial shift-add squarer (one partial product per clock). A sample is
// accepted only in IDLE; the result is presented with a one-cycle valid
// pulse and held until the next result.
module magnitude_squared_cal
   import magnitude_squared_cal_pkg::*;
#(
   parameter int unsigned INPUT_DATA_WIDTH  = MSC_INPUT_DATA_WIDTH,
   parameter int unsigned OUTPUT_DATA_WIDTH = MSC_OUTPUT_DATA_WIDTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         inputValid,
   input  logic [INPUT_DATA_WIDTH-1:0]  inputI,
   input  logic [INPUT_DATA_WIDTH-1:0]  inputQ,
   output logic                         inputReady,
   output logic                         outputValid,
   output logic [OUTPUT_DATA_WIDTH-1:0] outputData
);

   msc_state_e state_q, state_d;

   logic [INPUT_DATA_WIDTH-1:0]  mag_i_q, mag_i_d;
   logic [INPUT_DATA_WIDTH-1:0]  mag_q_q, mag_q_d;
   logic [OUTPUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                         out_valid_q, out_valid_d;

   logic [INPUT_DATA_WIDTH-1:0]  abs_i, abs_q;

   logic                         sq_clear;
   logic                         sq_step;
   logic [INPUT_DATA_WIDTH-1:0]  sq_operand;
   logic [OUTPUT_DATA_WIDTH-1:0] sq_acc;
   logic                         sq_last;

   // Two's-complement magnitude as an unsigned value; the most negative
   // sample maps to 2^(W-1) without saturation.
   assign abs_i = inputI[INPUT_DATA_WIDTH-1] ? -inputI : inputI;
   assign abs_q = inputQ[INPUT_DATA_WIDTH-1] ? -inputQ : inputQ;

   assign inputReady  = (state_q == ST_IDLE);
   assign outputValid = out_valid_q;
   assign outputData  = out_data_q;

   magnitude_squared_cal_serial_squarer #(
      .IN_W  (INPUT_DATA_WIDTH),
      .OUT_W (OUTPUT_DATA_WIDTH)
   ) u_squarer (
      .clk_i     (clock),
      .rst_ni    (reset),
      .clear_i   (sq_clear),
      .step_i    (sq_step),
      .operand_i (sq_operand),
      .acc_o     (sq_acc),
      .last_o    (sq_last)
   );

   // Sequencer: accept in IDLE, square I then Q into one accumulator,
   // publish the sum for exactly one cycle in DONE.
   always_comb begin
      state_d     = state_q;
      mag_i_d     = mag_i_q;
      mag_q_d     = mag_q_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      sq_clear    = 1'b0;
      sq_step     = 1'b0;
      sq_operand  = mag_i_q;
      case (state_q)
         ST_IDLE: begin
            if (inputValid) begin
               mag_i_d  = abs_i;
               mag_q_d  = abs_q;
               sq_clear = 1'b1;
               state_d  = ST_SQUARE_I;
            end
         end
         ST_SQUARE_I: begin
            sq_step    = 1'b1;
            sq_operand = mag_i_q;
            if (sq_last) begin
               state_d = ST_SQUARE_Q;
            end
         end
         ST_SQUARE_Q: begin
            sq_step    = 1'b1;
            sq_operand = mag_q_q;
            if (sq_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_data_d  = sq_acc;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched operand magnitudes and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         mag_i_q     <= '0;
         mag_q_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mag_i_q     <= mag_i_d;
         mag_q_q     <= mag_q_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_magnitude_squared_cal.sv
// Self-checking bench for magnitude_squared_cal: directed corner cases plus
// randomized samples compared against a plain-arithmetic I*I + Q*Q model.
module tb_magnitude_squared_cal;

   localparam int unsigned W   = 36;
   localparam int unsigned OW  = 72;
   localparam int unsigned LAT = 2 * W + 1;

   logic          clock      = 1'b0;
   logic          reset      = 1'b0;
   logic          inputValid = 1'b0;
   logic [W-1:0]  inputI     = '0;
   logic [W-1:0]  inputQ     = '0;
   logic          inputReady;
   logic          outputValid;
   logic [OW-1:0] outputData;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   magnitude_squared_cal #(
      .INPUT_DATA_WIDTH  (W),
      .OUTPUT_DATA_WIDTH (OW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .inputValid  (inputValid),
      .inputI      (inputI),
      .inputQ      (inputQ),
      .inputReady  (inputReady),
      .outputValid (outputValid),
      .outputData  (outputData)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: sign-extend and multiply with ordinary arithmetic.
   function automatic logic [OW-1:0] ref_mag2(input logic [W-1:0] i, input logic [W-1:0] q);
      logic signed [OW-1:0] si, sq;
      si = {{(OW - W){i[W-1]}}, i};
      sq = {{(OW - W){q[W-1]}}, q};
      return si * si + sq * sq;
   endfunction

   task automatic drive_junk();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      inputI = r[W-1:0];
      r = {$urandom(), $urandom()};
      inputQ = r[W-1:0];
   endtask

   // Waits (bounded) for the edge that accepts the sample currently driven;
   // returns how many edges it took. Called at posedge+1.
   task automatic wait_accept(input string tag, output int unsigned edges);
      bit rdy;
      bit done;
      edges = 0;
      done  = 0;
      for (int n = 0; n < 300 && !done; n++) begin
         rdy = inputReady;
         @(posedge clock);
         #1;
         edges++;
         if (rdy) done = 1;
      end
      if (!done) check_val({tag, "_accept_timeout"}, 0, 1);
      check_val({tag, "_ready_low"}, {{(OW-1){1'b0}}, inputReady}, 0);
   endtask

   // Counts edges from acceptance to the result pulse while scrambling the
   // inputs, then checks latency, data and handshake.
   task automatic wait_result(input logic [OW-1:0] exp, input bit hold, input string tag);
      int unsigned edges;
      bit seen;
      if (!hold) inputValid = 1'b0;
      edges = 0;
      seen  = 0;
      for (int n = 0; n < 300 && !seen; n++) begin
         drive_junk();
         @(posedge clock);
         #1;
         edges++;
         if (outputValid) seen = 1;
      end
      check_val({tag, "_latency"}, OW'(edges), OW'(LAT));
      check_val({tag, "_data"}, outputData, exp);
      check_val({tag, "_ready_with_valid"}, {{(OW-1){1'b0}}, inputReady}, 1);
      if (!hold) begin
         @(posedge clock);
         #1;
         check_val({tag, "_pulse_width"}, {{(OW-1){1'b0}}, outputValid}, 0);
         check_val({tag, "_data_hold"}, outputData, exp);
      end
   endtask

   task automatic run_one(input logic [W-1:0] i, input logic [W-1:0] q,
                          input logic [OW-1:0] exp, input string tag);
      int unsigned e;
      inputI     = i;
      inputQ     = q;
      inputValid = 1'b1;
      wait_accept(tag, e);
      wait_result(exp, 1'b0, tag);
   endtask

   initial begin
      int unsigned e;
      int unsigned stale;
      logic [OW-1:0] big;
      logic [W-1:0]  mn;
      logic [63:0]   r;
      logic [W-1:0]  ri, rq;

      // Reset state while held and right after release.
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_valid", {{(OW-1){1'b0}}, outputValid}, 0);
      check_val("rst_data", outputData, 0);
      check_val("rst_ready", {{(OW-1){1'b0}}, inputReady}, 1);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_val("post_rst_ready", {{(OW-1){1'b0}}, inputReady}, 1);

      // Directed values.
      run_one(W'(3), W'(4), OW'(25), "i3_q4");
      run_one(-W'(120), -W'(90), OW'(22500), "neg120_90");
      mn  = '0;
      mn[W-1] = 1'b1;
      big = '0;
      big[OW-1] = 1'b1;
      run_one(mn, mn, big, "most_negative");

      // Valid held high across three back-to-back samples.
      inputI = W'(1);
      inputQ = W'(1);
      inputValid = 1'b1;
      wait_accept("seq0", e);
      wait_result(OW'(2), 1'b1, "seq0");
      inputI = '0;
      inputQ = '0;
      wait_accept("seq1", e);
      check_val("seq1_accept_edge", OW'(e), OW'(1));
      wait_result(OW'(0), 1'b1, "seq1");
      inputI = -W'(7);
      inputQ = W'(24);
      wait_accept("seq2", e);
      check_val("seq2_accept_edge", OW'(e), OW'(1));
      wait_result(OW'(625), 1'b0, "seq2");

      // Asynchronous reset in the middle of the Q pass.
      inputI = W'(1000);
      inputQ = W'(2000);
      inputValid = 1'b1;
      wait_accept("abort", e);
      inputValid = 1'b0;
      repeat (W + 10) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check_val("abort_valid", {{(OW-1){1'b0}}, outputValid}, 0);
      check_val("abort_data", outputData, 0);
      check_val("abort_ready", {{(OW-1){1'b0}}, inputReady}, 1);
      @(negedge clock);
      reset = 1'b1;
      stale = 0;
      for (int n = 0; n < int'(LAT) + 10; n++) begin
         @(posedge clock);
         #1;
         if (outputValid) stale++;
      end
      check_val("abort_no_stale_pulse", OW'(stale), 0);
      check_val("abort_ready_after", {{(OW-1){1'b0}}, inputReady}, 1);
      run_one(W'(5), W'(12), OW'(169), "after_abort");

      // Zero operands overwrite the previous result.
      run_one('0, '0, '0, "zero");

      // Randomized full-range and small samples with random idle gaps.
      for (int k = 0; k < 16; k++) begin
         r  = {$urandom(), $urandom()};
         ri = r[W-1:0];
         r  = {$urandom(), $urandom()};
         rq = r[W-1:0];
         if (k % 4 == 3) begin
            ri = W'($signed($urandom_range(0, 2000)) - 1000);
            rq = W'($signed($urandom_range(0, 2000)) - 1000);
         end
         inputValid = 1'b0;
         repeat ($urandom_range(0, 3)) @(posedge clock);
         #1;
         run_one(ri, rq, ref_mag2(ri, rq), $sformatf("rand%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
